// File: rtl/alu_arb_pkg.sv
// Shared types for the ALU arbiter: FSM states, in-flight tag, data width.
// Tag id is sized for up to 256 requesters; the top uses the low IDW bits.
package alu_arb_pkg;

    localparam int DW      = 32;
    localparam int TAG_IDW = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    typedef struct packed {
        logic               valid;
        logic [TAG_IDW-1:0] id;
    } tag_t;

endpackage

// File: rtl/alu_arb_rr_pick.sv
// Next-grant picker: first valid requester at or after i_ptr (mod NREQ).
// ALU_ARB_FIXED_PRIO_EN turns it into a lowest-index priority encoder.
module alu_arb_rr_pick #(
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_valid,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_gnt_id,
    output logic            o_any
);

`ifdef ALU_ARB_FIXED_PRIO_EN
    logic w_unused_ptr;
    assign w_unused_ptr = ^i_ptr;

    always_comb begin
        o_gnt    = '0;
        o_gnt_id = '0;
        o_any    = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (i_valid[i]) begin
                o_gnt_id = IDW'(i);
                o_any    = 1'b1;
            end
        end
        if (o_any) o_gnt[o_gnt_id] = 1'b1;
    end
`else
    int w_idx;

    // Scan from the farthest offset down so the nearest valid one wins.
    always_comb begin
        o_gnt    = '0;
        o_gnt_id = '0;
        o_any    = 1'b0;
        w_idx    = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = (int'(i_ptr) + k) % NREQ;
            if (i_valid[w_idx]) begin
                o_gnt_id = IDW'(w_idx);
                o_any    = 1'b1;
            end
        end
        if (o_any) o_gnt[o_gnt_id] = 1'b1;
    end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one STAGES-deep add/sub ALU between NREQ requesters with tagged returns.
// Define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int STAGES = 3,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ-1:0]    req_sel,
    input  logic [NREQ*DW-1:0] req_a,
    input  logic [NREQ*DW-1:0] req_b,
    input  logic [NREQ-1:0]    req_c,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_r,
    input  logic               drain,
    output logic               idle,
    output logic               alu_sel,
    output logic               alu_c,
    output logic [DW-1:0]      alu_a,
    output logic [DW-1:0]      alu_b,
    input  logic [DW-1:0]      alu_r
);

    state_t          r_state;
    state_t          w_state_nxt;
    tag_t            r_issue;
    tag_t            r_pipe [STAGES];
    logic [NREQ-1:0] w_gnt;
    logic [IDW-1:0]  w_gnt_id;
    logic [IDW-1:0]  w_ptr;
    logic            w_any;
    logic            w_can_grant;
    logic            w_xfer;
    logic            w_tags_any;
    logic            w_tags_after;
    logic            w_unused_tag;

    alu_arb_rr_pick #(.NREQ(NREQ)) u_pick (
        .i_valid (req_valid),
        .i_ptr   (w_ptr),
        .o_gnt   (w_gnt),
        .o_gnt_id(w_gnt_id),
        .o_any   (w_any)
    );

    // Grants are masked during reset so nothing transfers while rst is high.
    assign w_can_grant = !rst && !drain && (r_state != ST_DRAIN);
    assign w_xfer      = w_can_grant && w_any;
    assign req_ready   = w_can_grant ? w_gnt : '0;
    assign idle        = (r_state == ST_IDLE) && !w_xfer;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    logic [IDW-1:0] r_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + 1'b1;
        end
    end

    assign w_ptr = r_ptr;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_sel <= 1'b0;
            alu_c   <= 1'b0;
            alu_a   <= '0;
            alu_b   <= '0;
        end else if (w_xfer) begin
            alu_sel <= req_sel[w_gnt_id];
            alu_c   <= req_c[w_gnt_id];
            alu_a   <= req_a[int'(w_gnt_id)*DW +: DW];
            alu_b   <= req_b[int'(w_gnt_id)*DW +: DW];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_issue <= '0;
            for (int s = 0; s < STAGES; s++) r_pipe[s] <= '0;
        end else begin
            r_issue.valid <= w_xfer;
            r_issue.id    <= TAG_IDW'(w_gnt_id);
            r_pipe[0]     <= r_issue;
            for (int s = 1; s < STAGES; s++) r_pipe[s] <= r_pipe[s-1];
        end
    end

    // w_tags_after: anything still in flight once the last entry retires.
    always_comb begin
        w_tags_after = r_issue.valid;
        for (int s = 0; s < STAGES - 1; s++) w_tags_after |= r_pipe[s].valid;
        w_tags_any = w_tags_after | r_pipe[STAGES-1].valid;
    end

    always_comb begin
        rsp_valid = '0;
        if (r_pipe[STAGES-1].valid) rsp_valid[r_pipe[STAGES-1].id[IDW-1:0]] = 1'b1;
    end

    assign rsp_r        = alu_r;
    assign w_unused_tag = ^r_pipe[STAGES-1].id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (drain)                       w_state_nxt = ST_DRAIN;
                else if (!w_tags_any && !w_xfer) w_state_nxt = ST_IDLE;
            end
            ST_DRAIN: begin
                if (!w_tags_after) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a 3-stage add/sub ALU model.
// Directed vectors; a monitor checks every response against the queue.
module tb_alu_arbiter;

    localparam int NREQ = 4;
    localparam int STG  = 3;

    typedef struct {
        int          id;
        logic [31:0] r;
        int          cyc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0]      req_valid = '0;
    logic [3:0]      req_ready;
    logic [3:0]      req_sel = '0;
    logic [127:0]    req_a = '0;
    logic [127:0]    req_b = '0;
    logic [3:0]      req_c = '0;
    logic [3:0]      rsp_valid;
    logic [31:0]     rsp_r;
    logic            drain = 1'b0;
    logic            idle;
    logic            alu_sel;
    logic            alu_c;
    logic [31:0]     alu_a;
    logic [31:0]     alu_b;
    logic [31:0]     alu_r;
    logic [31:0]     s0, s1, s2;

    exp_t            sb[$];
    int              gids[$];
    logic [31:0]     etab [4];
    int              n_vec = 0;
    int              n_err = 0;
    int              cyc = 0;

    alu_arbiter #(.NREQ(NREQ), .STAGES(STG)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_sel(req_sel), .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .rsp_valid(rsp_valid), .rsp_r(rsp_r),
        .drain(drain), .idle(idle),
        .alu_sel(alu_sel), .alu_c(alu_c), .alu_a(alu_a), .alu_b(alu_b),
        .alu_r(alu_r)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External ALU: three register stages, no reset.
    always @(posedge clk) begin
        s0 <= alu_sel ? alu_a + alu_b + {31'd0, alu_c}
                      : alu_a - alu_b - {31'd0, alu_c};
        s1 <= s0;
        s2 <= s1;
    end
    assign alu_r = s2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid !== 4'b0) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", {28'd0, rsp_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_onehot", {28'd0, rsp_valid}, 32'd1 << e.id);
                chk("rsp_r", rsp_r, e.r);
                chk("latency", cyc - e.cyc, STG + 1);
            end
        end
    end

    task automatic set_op(input int i, input logic sel, input logic [31:0] a,
                          input logic [31:0] b, input logic c, input logic [31:0] exp);
        req_sel[i]        = sel;
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_c[i]          = c;
        etab[i]           = exp;
    endtask

    // Waits for n transfers; returns at the negedge of the n-th grant.
    task automatic run_grants(input int n, input bit push);
        int   cnt;
        exp_t e;
        cnt = 0;
        for (int t = 0; t < 40 && cnt < n; t++) begin
            @(negedge clk);
            if ((req_ready & req_valid) != 0) begin
                chk("ready_onehot", {31'd0, $onehot(req_ready)}, 32'd1);
                for (int i = 0; i < NREQ; i++) begin
                    if (req_ready[i] && req_valid[i]) begin
                        gids.push_back(i);
                        if (push) begin
                            e.id  = i;
                            e.r   = etab[i];
                            e.cyc = cyc;
                            sb.push_back(e);
                        end
                    end
                end
                cnt++;
            end
        end
        if (cnt != n) chk("grant_timeout", cnt, n);
    endtask

    task automatic wait_empty();
        for (int t = 0; t < 30 && sb.size() != 0; t++) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
    endtask

    initial begin
        int nr;
        int exp_ids [5];

        req_valid = 4'hF;
        repeat (2) @(negedge clk);
        chk("rst_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_rsp", {28'd0, rsp_valid}, 32'd0);
        chk("rst_idle", {31'd0, idle}, 32'd1);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_sc", {30'd0, alu_sel, alu_c}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = '0;
        repeat (2) @(posedge clk);

        // Contention from ptr 0
        for (int i = 0; i < NREQ; i++) set_op(i, 1'b1, i + 1, 32'd10, 1'b0, 32'd11 + i);
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_ids = '{0, 0, 0, 0, 0};
`else
        exp_ids = '{0, 1, 2, 3, 0};
`endif
        #1 req_valid = 4'hF;
        gids.delete();
        run_grants(5, 1'b1);
        @(posedge clk); #1 req_valid = '0;
        for (int j = 0; j < 5; j++) chk("grant_order", gids[j], exp_ids[j]);
        wait_empty();

        // Single op, then wrap/borrow and other arithmetic corners
        @(posedge clk); #1;
        set_op(2, 1'b1, 32'd5, 32'd7, 1'b1, 32'd13);
        req_valid = 4'b0100;
        run_grants(1, 1'b1);
        @(posedge clk); #1;
        set_op(1, 1'b0, 32'd0, 32'd1, 1'b1, 32'hFFFF_FFFE);
        req_valid = 4'b0010;
        run_grants(1, 1'b1);
        @(posedge clk); #1;
        set_op(0, 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0);
        req_valid = 4'b0001;
        run_grants(1, 1'b1);
        @(posedge clk); #1;
        set_op(3, 1'b0, 32'd10, 32'd3, 1'b0, 32'd7);
        req_valid = 4'b1000;
        run_grants(1, 1'b1);
        @(posedge clk); #1 req_valid = '0;
        wait_empty();

        // Drain with three ops in flight and requests held
        @(posedge clk); #1;
        set_op(0, 1'b0, 32'd50, 32'd8, 1'b1, 32'd41);
        set_op(1, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'd1);
        set_op(3, 1'b0, 32'd7, 32'd7, 1'b0, 32'd0);
        req_valid = 4'b1011;
        run_grants(3, 1'b1);
        @(posedge clk); #1 drain = 1'b1;
        nr = 0;
        for (int t = 0; t < 20 && nr < 3; t++) begin
            @(negedge clk);
            chk("drain_ready", {28'd0, req_ready}, 32'd0);
            if (rsp_valid != 0) nr++;
        end
        chk("drain_rsp_cnt", nr, 3);
        @(negedge clk);
        chk("drain_idle", {31'd0, idle}, 32'd1);
        @(posedge clk); #1;
        drain = 1'b0;
        req_valid = '0;
        wait_empty();

        // Drain and request together from IDLE
        @(posedge clk); #1;
        drain = 1'b1;
        req_valid = 4'b0100;
        repeat (3) begin
            @(negedge clk);
            chk("dreq_ready", {28'd0, req_ready}, 32'd0);
            chk("dreq_idle", {31'd0, idle}, 32'd1);
        end
        @(posedge clk); #1;
        drain = 1'b0;
        req_valid = '0;

        // Reset with two ops in flight
        @(posedge clk); #1;
        set_op(0, 1'b1, 32'd1, 32'd1, 1'b0, 32'd2);
        set_op(1, 1'b1, 32'd2, 32'd2, 1'b0, 32'd4);
        req_valid = 4'b0011;
        run_grants(2, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = 4'b1000;
        repeat (2) begin
            @(negedge clk);
            chk("mrst_ready", {28'd0, req_ready}, 32'd0);
            chk("mrst_idle", {31'd0, idle}, 32'd1);
            chk("mrst_rsp", {28'd0, rsp_valid}, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = '0;
        @(negedge clk);
        chk("mrst_alu_a", alu_a, 32'd0);
        repeat (8) @(negedge clk);
        @(posedge clk); #1;
        set_op(3, 1'b1, 32'd1000, 32'd234, 1'b0, 32'd1234);
        req_valid = 4'b1000;
        run_grants(1, 1'b1);
        @(posedge clk); #1 req_valid = '0;
        wait_empty();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
